// File: rtl/rle_packer.sv
// Run-token packer: buffers (char, count) tokens in a small FIFO and serialises
// each run as an ASCII character followed by its length digit over valid/ready.
module rle_packer #(
    parameter int DEPTH    = 4,
    parameter bit SKIP_ONE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic [2:0] count,
    input  logic       valid,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       full,
    output logic       overflow
);
    // state | meaning
    // IDLE  | nothing presented; pop the FIFO head when one is available
    // CHAR  | presenting the run character
    // DIGIT | presenting the run length digit
    typedef enum logic [1:0] {IDLE, CHAR, DIGIT} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [10:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          empty, push, pop, run_done;
    logic [10:0]   head;
    logic [7:0]    out_d, digit;
    logic [2:0]    cnt_q, cnt_d;
    state_t        state_q, state_d;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = valid && !full;
    assign head  = mem[rd_ptr[AW-1:0]];

    // A count of 0 is the counter's wrap and stands for a run of 8.
    assign digit = (cnt_q == 3'd0) ? 8'h38 : (8'h30 + {5'd0, cnt_q});

    assign out_valid = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        out_d    = out;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        run_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    out_d   = head[7:0];
                    cnt_d   = head[10:8];
                    state_d = CHAR;
                end
            end
            CHAR: begin
                if (out_ready) begin
                    if (SKIP_ONE && cnt_q == 3'd1) begin
                        run_done = 1'b1;
                    end else begin
                        out_d   = digit;
                        state_d = DIGIT;
                    end
                end
            end
            DIGIT: begin
                if (out_ready) run_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Chain straight into the next run so back-to-back tokens have no gap.
        if (run_done) begin
            if (!empty) begin
                pop     = 1'b1;
                out_d   = head[7:0];
                cnt_d   = head[10:8];
                state_d = CHAR;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            out      <= 8'h00;
            cnt_q    <= 3'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            out     <= out_d;
            cnt_q   <= cnt_d;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (valid && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {count, data};
    end
endmodule

// File: doc/rle_packer.md
# rle_packer

Downstream stage of the text run counter. Consumes its (DATA, COUNT, VALID) run tokens, buffers them in a small FIFO, and serialises each run into an ASCII byte stream: the character, then its run length as an ASCII digit. Output uses a valid/ready handshake, so a slow sink (UART or transmit buffer) can stall it without losing tokens until the FIFO fills.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- SKIP_ONE, 0: when 1, runs of length 1 emit the character only, with no digit.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset. One clock; reset is asynchronous and active-low.
- DATA  input  8  run character from the counter stage.
- COUNT  input  3  run length. 1..7 literal; 0 means 8 (counter wrap).
- VALID  input  1  one-cycle strobe; DATA/COUNT are a token this cycle.
- OUT  output  8  serialised byte.
- OUT_VALID  output  1  OUT holds a byte for the sink.
- OUT_READY  input  1  sink accepts OUT this cycle.
- FULL  output  1  FIFO holds DEPTH entries.
- OVERFLOW  output  1  sticky; a token was dropped because the FIFO was full.

## Operation
- FIFO: DEPTH x 11 bits ({COUNT, DATA}), with read and write pointers of log2(DEPTH)+1 bits. FULL is set when the pointers differ only in the MSB; empty is set when the pointers are equal.
- Push: VALID=1 and FULL=0 at the edge writes the token.
  - VALID=1 with FULL=1 drops the token and sets OVERFLOW, even if a pop happens in the same cycle.
  - OVERFLOW clears only on reset.
- Digit encoding: OUT = 8'h30 + COUNT for COUNT 1..7. COUNT 0 gives 8'h38 ('8').
- FSM states:
  - IDLE: OUT_VALID=0. If the FIFO is not empty, pop the head, load OUT=char, latch the count, and go to CHAR.
  - CHAR: OUT_VALID=1, OUT=char. On OUT_VALID&OUT_READY:
    - if SKIP_ONE=1 and count==1, take the digit-done path below;
    - otherwise load OUT=digit and go to DIGIT.
  - DIGIT: OUT_VALID=1, OUT=digit. On transfer (digit-done path):
    - if the FIFO is not empty, pop, load the next char, and stay in CHAR;
    - else go to IDLE.
- Holding rule: while OUT_VALID=1 and OUT_READY=0, OUT and the state do not change.
- Push and pop may occur in the same cycle. The occupancy count stays consistent; a push to an empty FIFO is not seen by the FSM until the following cycle.
- Pointers wrap modulo 2*DEPTH. Entries are emitted in strict arrival order.

## Timing
- Reset values (immediate on RST=0, independent of CLK): state IDLE, OUT=8'h00, OUT_VALID=0, FULL=0, OVERFLOW=0, pointers 0. Any in-flight byte and all FIFO contents are discarded.
- A token pushed at edge N into an empty FIFO with the FSM in IDLE appears as OUT=char, OUT_VALID=1 after edge N+1.
- With OUT_READY held at 1, each run takes 2 cycles (1 cycle when skipped). Back-to-back tokens stream with no idle cycle between runs.
- A pop frees an entry at that edge, so FULL can fall in the cycle after the pop.
- Capacity before a drop with the sink stalled: DEPTH tokens in the FIFO plus 1 held in the output register.
- OUT_VALID never drops without a transfer, except on reset.

## Test plan
- Single run: token 'a'(0x61), COUNT=3, with OUT_READY=1 -> OUT 0x61 then 0x33 on consecutive cycles, starting 1 cycle after the push, then OUT_VALID=0.
- Wrap and stream: tokens 'c'/2, 'd'/0, 'b'/1 on consecutive strobes, OUT_READY=1 -> 0x63,0x32,0x64,0x38,0x62,0x31 with no gaps.
- Backpressure: 'a'/4 with OUT_READY low for 5 cycles, then high -> OUT held at 0x61 with OUT_VALID=1 throughout the stall, then 0x61 and 0x34 transfer once each.
- Overflow: OUT_READY=0, 6 tokens pushed with DEPTH=4 -> FULL=1 after the 5th, 6th dropped, OVERFLOW=1. Releasing the sink yields exactly 5 runs in order, and OVERFLOW stays 1.
- SKIP_ONE=1: 'b'/1 then 'd'/2 -> stream 0x62,0x64,0x32.
- Reset mid-operation: assert RST while in DIGIT with 2 tokens queued -> OUT_VALID=0 and FULL=0 immediately. After release, with no new tokens, no output appears.
